// File: rtl/relu_maxpool_stream.sv
// Streaming ReLU followed by 2x2 / stride-2 max-pooling on a row-major conv map.
// Horizontal maxima of even rows wait in a half-row line buffer for their odd-row partner.
module relu_maxpool_stream #(
   parameter int DATA_WIDTH  = 16,
   parameter int IMAGE_SIZE  = 28,
   parameter int KERNEL_SIZE = 5,
   parameter int OUT_SIZE    = IMAGE_SIZE - KERNEL_SIZE + 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] conv_in,
   input  logic                  valid_in,
   output logic [DATA_WIDTH-1:0] pool_out,
   output logic                  valid_out,
   output logic                  frame_done
);

   localparam int CW   = (OUT_SIZE > 2) ? $clog2(OUT_SIZE) : 1;
   localparam int HALF = OUT_SIZE / 2;
   localparam int AW   = (HALF > 1) ? $clog2(HALF) : 1;
   localparam logic [CW-1:0] LAST_IDX = CW'(OUT_SIZE - 1);

   logic [CW-1:0]         col_reg, row_reg;
   logic [DATA_WIDTH-1:0] hold_reg, pool_reg;
   logic                  valid_reg, done_reg;
   logic [DATA_WIDTH-1:0] linebuf [HALF];

   logic [DATA_WIDTH-1:0] relu_val, h_max, lb_rd, v_max;
   logic [AW-1:0]         lb_addr;
   logic                  col_last, row_last;

   // After ReLU every operand is non-negative, so unsigned compares are exact.
   always_comb begin
      relu_val = conv_in[DATA_WIDTH-1] ? '0 : conv_in;
      h_max    = (hold_reg >= relu_val) ? hold_reg : relu_val;
      lb_addr  = AW'(col_reg >> 1);
      lb_rd    = linebuf[lb_addr];
      v_max    = (lb_rd >= h_max) ? lb_rd : h_max;
      col_last = (col_reg == LAST_IDX);
      row_last = (row_reg == LAST_IDX);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         col_reg   <= '0;
         row_reg   <= '0;
         hold_reg  <= '0;
         pool_reg  <= '0;
         valid_reg <= 1'b0;
         done_reg  <= 1'b0;
      end else begin
         valid_reg <= 1'b0;
         done_reg  <= 1'b0;
         if (valid_in) begin
            if (col_last) begin
               col_reg <= '0;
               row_reg <= row_last ? '0 : row_reg + 1'b1;
            end else begin
               col_reg <= col_reg + 1'b1;
            end
            if (!col_reg[0]) begin
               hold_reg <= relu_val;
            end else if (row_reg[0]) begin
               pool_reg  <= v_max;
               valid_reg <= 1'b1;
               done_reg  <= col_last && row_last;
            end
         end
      end
   end

   // No reset on the line buffer: every entry is written on an even row before
   // the odd row reads it.
   always_ff @(posedge clk) begin
      if (!reset && valid_in && col_reg[0] && !row_reg[0]) begin
         linebuf[lb_addr] <= h_max;
      end
   end

   assign pool_out   = pool_reg;
   assign valid_out  = valid_reg;
   assign frame_done = done_reg;

endmodule
